vga_timing_ctrl: RTL

- VGA/LCD timing generator and output stage for the 800x480 panel.
- Free-running horizontal and vertical counters produce hsync, vsync and data-enable (de).
- Drives pix_x/pix_y/pix_req to the picture-generation stage PIX_LEAD cycles ahead of display, so that stage's registered ROM/RAM latency is absorbed.
- Registers the returned 24-bit colour onto the panel pins, aligned with sync and de.

---
 rtl/vga_timing_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 800x480 panel timing generator and output stage.
// Free-running counters produce hsync/vsync/de. Pixel coordinates are requested
// PIX_LEAD cycles ahead of display so that the picture stage's registered latency
// is absorbed. The returned colour is registered onto the panel pins, aligned
// with sync and de.
// Optional build macro: VGA_TEST_PATTERN_EN adds pattern_sel, which replaces
// color_in with 8 vertical colour bars.
module vga_timing_ctrl #(
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BACK    = 88,
  parameter int unsigned H_VALID   = 800,
  parameter int unsigned H_FRONT   = 40,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned V_VALID   = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned PIX_LEAD  = 2,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  input  logic [23:0] color_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_req,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_END = 11'(H_SYNC);
  localparam logic [10:0] VS_END = 11'(V_SYNC);
  localparam logic [10:0] HA     = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HE     = 11'(H_SYNC + H_BACK + H_VALID);
  localparam logic [10:0] VA     = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] VE     = 11'(V_SYNC + V_BACK + V_VALID);
  // Request window is the active window shifted left by PIX_LEAD; it stays
  // inside the line because PIX_LEAD never exceeds the sync+back porch.
  localparam logic [10:0] RS     = 11'(H_SYNC + H_BACK - PIX_LEAD);
  localparam logic [10:0] RE     = 11'(H_SYNC + H_BACK + H_VALID - PIX_LEAD);

  logic [10:0] cnt_h_q, cnt_h_d;
  logic [10:0] cnt_v_q, cnt_v_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [23:0] rgb_q, rgb_d;
  logic        frame_start_q, frame_start_d;

  logic        h_act, v_act, act, req_h;
  logic [23:0] src_color;

  // Counter advance: horizontal wraps every line, vertical steps on the last pixel.
  always_comb begin
    cnt_h_d = cnt_h_q + 11'd1;
    cnt_v_d = cnt_v_q;
    if (cnt_h_q == H_LAST) begin
      cnt_h_d = '0;
      cnt_v_d = (cnt_v_q == V_LAST) ? '0 : cnt_v_q + 11'd1;
    end
  end

  // Region decode and the combinational pixel request toward the picture stage.
  always_comb begin
    h_act   = (cnt_h_q >= HA) && (cnt_h_q < HE);
    v_act   = (cnt_v_q >= VA) && (cnt_v_q < VE);
    act     = h_act && v_act;
    req_h   = (cnt_h_q >= RS) && (cnt_h_q < RE);
    pix_req = req_h && v_act;
    pix_x   = pix_req ? 10'(cnt_h_q - RS) : 10'h3FF;
    pix_y   = pix_req ? 10'(cnt_v_q - VA) : 10'h3FF;
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_VALID / 8);
  logic [10:0] bar_pos;
  logic [2:0]  bar_idx;
  logic [23:0] bar_color;

  // Colour-bar source; bar_idx is only meaningful inside the active window.
  always_comb begin
    bar_pos = cnt_h_q - HA;
    bar_idx = 3'(bar_pos / BAR_W);
    case (bar_idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
    src_color = pattern_sel ? bar_color : color_in;
  end
`else
  // Without the test pattern the panel always shows the picture stage colour.
  always_comb begin
    src_color = color_in;
  end
`endif

  // Next values of the panel-side outputs, all one cycle behind the counters.
  always_comb begin
    hsync_d       = (cnt_h_q < HS_END) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = (cnt_v_q < VS_END) ? VSYNC_POL : ~VSYNC_POL;
    de_d          = act;
    rgb_d         = act ? src_color : 24'h000000;
    frame_start_d = (cnt_h_q == 11'd0) && (cnt_v_q == 11'd0);
  end

  // State and output registers; reset drops everything to idle blanking at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_h_q       <= '0;
      cnt_v_q       <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;

endmodule
